// File: rtl/issue_select_multi.sv
// Multi-issue select stage between the reservation-station array and the
// execute units.
//
// Each cycle the stations are scanned in round-robin order starting at
// rr_ptr. Each eligible station (busy, both source tags zero) is handed to
// the next free issue port, in ascending port order. Every port has a
// registered slot with a valid/ready handshake. rs_grant tells the RS array
// which stations issued, so it can free them at the same edge.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   rs_*              flattened per-station fields from the RS array
//   rs_grant          combinational, one bit per station issued this cycle
//   iss_valid/ready   per-port handshake
//   iss_src_a/src_b   operands (src_b is the immediate when alusrc is set)
//   iss_data          store data (value_2 when memwr is set, else 0)
//   iss_ctrl/rs_id/tag copied from the station
//
// Optional build macro ISSUE_PERF_EN adds the perf_issued and perf_stall
// saturating counters.
module issue_select_multi #(
   parameter int RS_DEPTH    = 8,
   parameter int ISSUE_WIDTH = 2,
   parameter int DATA_W      = 32,
   parameter int TAG_W       = 6,
   parameter int ID_W        = 5,
   parameter int CTRL_W      = 16,
   parameter int ALUSRC_BIT  = 0,
   parameter int MEMWR_BIT   = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [RS_DEPTH-1:0]           rs_busy,
   input  logic [RS_DEPTH*TAG_W-1:0]     rs_tag_1,
   input  logic [RS_DEPTH*TAG_W-1:0]     rs_tag_2,
   input  logic [RS_DEPTH*DATA_W-1:0]    rs_value_1,
   input  logic [RS_DEPTH*DATA_W-1:0]    rs_value_2,
   input  logic [RS_DEPTH*DATA_W-1:0]    rs_imm,
   input  logic [RS_DEPTH*CTRL_W-1:0]    rs_ctrl,
   input  logic [RS_DEPTH*ID_W-1:0]      rs_id,
   input  logic [RS_DEPTH*TAG_W-1:0]     rs_dest_tag,
   output logic [RS_DEPTH-1:0]           rs_grant,
   output logic [ISSUE_WIDTH-1:0]        iss_valid,
   input  logic [ISSUE_WIDTH-1:0]        iss_ready,
   output logic [ISSUE_WIDTH*DATA_W-1:0] iss_src_a,
   output logic [ISSUE_WIDTH*DATA_W-1:0] iss_src_b,
   output logic [ISSUE_WIDTH*DATA_W-1:0] iss_data,
   output logic [ISSUE_WIDTH*CTRL_W-1:0] iss_ctrl,
   output logic [ISSUE_WIDTH*ID_W-1:0]   iss_rs_id,
   output logic [ISSUE_WIDTH*TAG_W-1:0]  iss_tag
`ifdef ISSUE_PERF_EN
   ,
   output logic [31:0]                   perf_issued,
   output logic [31:0]                   perf_stall
`endif
);

   localparam int PTR_W = $clog2(RS_DEPTH);

   logic [PTR_W-1:0]       rr_ptr;
   logic [RS_DEPTH-1:0]    eligible;
   logic [ISSUE_WIDTH-1:0] port_free;
   logic [ISSUE_WIDTH-1:0] sel_valid;
   logic [PTR_W-1:0]       sel_idx [ISSUE_WIDTH];
   logic [PTR_W-1:0]       last_idx;
   logic [PTR_W-1:0]       idx;
   logic                   placed;
   logic                   any_grant;
   logic [RS_DEPTH-1:0]    grant;

   logic [DATA_W-1:0]      ld_a    [ISSUE_WIDTH];
   logic [DATA_W-1:0]      ld_b    [ISSUE_WIDTH];
   logic [DATA_W-1:0]      ld_data [ISSUE_WIDTH];
   logic [CTRL_W-1:0]      ld_ctrl [ISSUE_WIDTH];
   logic [ID_W-1:0]        ld_id   [ISSUE_WIDTH];
   logic [TAG_W-1:0]       ld_tag  [ISSUE_WIDTH];

   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++)
         eligible[i] = rs_busy[i] && (rs_tag_1[i*TAG_W +: TAG_W] == '0)
                                  && (rs_tag_2[i*TAG_W +: TAG_W] == '0);
   end

   assign port_free = ~iss_valid | iss_ready;

   // Walk stations in round-robin order; each eligible station takes the
   // lowest-numbered free port not yet filled. RS_DEPTH is a power of two,
   // so the PTR_W-bit add wraps modulo RS_DEPTH.
   always_comb begin
      grant     = '0;
      sel_valid = '0;
      last_idx  = rr_ptr;
      any_grant = 1'b0;
      idx       = '0;
      placed    = 1'b0;
      for (int p = 0; p < ISSUE_WIDTH; p++)
         sel_idx[p] = '0;
      for (int k = 0; k < RS_DEPTH; k++) begin
         idx    = rr_ptr + PTR_W'(k);
         placed = 1'b0;
         if (eligible[idx]) begin
            for (int p = 0; p < ISSUE_WIDTH; p++) begin
               if (!placed && port_free[p] && !sel_valid[p]) begin
                  sel_valid[p] = 1'b1;
                  sel_idx[p]   = idx;
                  placed       = 1'b1;
               end
            end
            if (placed) begin
               grant[idx] = 1'b1;
               last_idx   = idx;
               any_grant  = 1'b1;
            end
         end
      end
   end

   assign rs_grant = reset ? '0 : grant;

   always_comb begin
      for (int p = 0; p < ISSUE_WIDTH; p++) begin
         ld_ctrl[p] = rs_ctrl[int'(sel_idx[p])*CTRL_W +: CTRL_W];
         ld_id[p]   = rs_id[int'(sel_idx[p])*ID_W +: ID_W];
         ld_tag[p]  = rs_dest_tag[int'(sel_idx[p])*TAG_W +: TAG_W];
         ld_a[p]    = rs_value_1[int'(sel_idx[p])*DATA_W +: DATA_W];
         ld_b[p]    = ld_ctrl[p][ALUSRC_BIT] ? rs_imm[int'(sel_idx[p])*DATA_W +: DATA_W]
                                             : rs_value_2[int'(sel_idx[p])*DATA_W +: DATA_W];
         ld_data[p] = ld_ctrl[p][MEMWR_BIT] ? rs_value_2[int'(sel_idx[p])*DATA_W +: DATA_W]
                                            : '0;
      end
   end

   // A free port without a new entry only drops valid; payload is left as-is.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr    <= '0;
         iss_valid <= '0;
         iss_src_a <= '0;
         iss_src_b <= '0;
         iss_data  <= '0;
         iss_ctrl  <= '0;
         iss_rs_id <= '0;
         iss_tag   <= '0;
      end else begin
         for (int p = 0; p < ISSUE_WIDTH; p++) begin
            if (port_free[p]) begin
               iss_valid[p] <= sel_valid[p];
               if (sel_valid[p]) begin
                  iss_src_a[p*DATA_W +: DATA_W] <= ld_a[p];
                  iss_src_b[p*DATA_W +: DATA_W] <= ld_b[p];
                  iss_data[p*DATA_W +: DATA_W]  <= ld_data[p];
                  iss_ctrl[p*CTRL_W +: CTRL_W]  <= ld_ctrl[p];
                  iss_rs_id[p*ID_W +: ID_W]     <= ld_id[p];
                  iss_tag[p*TAG_W +: TAG_W]     <= ld_tag[p];
               end
            end
         end
         if (any_grant)
            rr_ptr <= last_idx + PTR_W'(1);
      end
   end

`ifdef ISSUE_PERF_EN
   logic [2:0]  grant_cnt;
   logic [32:0] issued_sum;

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < RS_DEPTH; i++)
         grant_cnt = grant_cnt + 3'(grant[i]);
      issued_sum = {1'b0, perf_issued} + 33'(grant_cnt);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         perf_issued <= issued_sum[32] ? '1 : issued_sum[31:0];
         if ((|eligible) && !(|port_free) && (perf_stall != '1))
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_issue_select_multi.sv
module tb_issue_select_multi;

   localparam int D  = 8;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [D-1:0]      rs_busy;
   logic [D*6-1:0]    rs_tag_1, rs_tag_2, rs_dest_tag;
   logic [D*32-1:0]   rs_value_1, rs_value_2, rs_imm;
   logic [D*16-1:0]   rs_ctrl;
   logic [D*5-1:0]    rs_id;
   logic [D-1:0]      rs_grant;
   logic [IW-1:0]     iss_valid, iss_ready;
   logic [IW*32-1:0]  iss_src_a, iss_src_b, iss_data;
   logic [IW*16-1:0]  iss_ctrl;
   logic [IW*5-1:0]   iss_rs_id;
   logic [IW*6-1:0]   iss_tag;

   int n_checks = 0;
   int n_errors = 0;

   issue_select_multi dut (
      .clk(clk), .reset(reset),
      .rs_busy(rs_busy), .rs_tag_1(rs_tag_1), .rs_tag_2(rs_tag_2),
      .rs_value_1(rs_value_1), .rs_value_2(rs_value_2), .rs_imm(rs_imm),
      .rs_ctrl(rs_ctrl), .rs_id(rs_id), .rs_dest_tag(rs_dest_tag),
      .rs_grant(rs_grant),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_src_a(iss_src_a), .iss_src_b(iss_src_b), .iss_data(iss_data),
      .iss_ctrl(iss_ctrl), .iss_rs_id(iss_rs_id), .iss_tag(iss_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_entry(input int i, input logic [5:0] t1, input logic [5:0] t2,
                            input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                            input logic [15:0] ctrl, input logic [5:0] dest);
      rs_busy[i]            = 1'b1;
      rs_tag_1[i*6 +: 6]    = t1;
      rs_tag_2[i*6 +: 6]    = t2;
      rs_value_1[i*32 +: 32] = v1;
      rs_value_2[i*32 +: 32] = v2;
      rs_imm[i*32 +: 32]     = imm;
      rs_ctrl[i*16 +: 16]    = ctrl;
      rs_id[i*5 +: 5]        = 5'(i);
      rs_dest_tag[i*6 +: 6]  = dest;
   endtask

   // Each step starts 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      rs_busy = '0; rs_tag_1 = '0; rs_tag_2 = '0; rs_dest_tag = '0;
      rs_value_1 = '0; rs_value_2 = '0; rs_imm = '0; rs_ctrl = '0; rs_id = '0;
      iss_ready = '0;
      tick(); tick();
      check("reset_valid", 64'(iss_valid), 64'h0);
      check("reset_src_a", 64'(iss_src_a), 64'h0);
      check("reset_tag",   64'(iss_tag),   64'h0);
      reset = 1'b0;
      #1;

      // Entries 2 and 5 eligible, rr_ptr 0.
      set_entry(2, 0, 0, 32'hA2, 32'hB2, 32'hC2, 16'h0A00, 6'h12);
      set_entry(5, 0, 0, 32'hA5, 32'hB5, 32'hC5, 16'h0500, 6'h15);
      #1;
      check("s1_grant", 64'(rs_grant), 64'b0010_0100);
      tick();
      rs_busy[2] = 1'b0; rs_busy[5] = 1'b0;
      check("s1_valid",  64'(iss_valid),        64'b11);
      check("s1_p0_id",  64'(iss_rs_id[4:0]),   64'd2);
      check("s1_p1_id",  64'(iss_rs_id[9:5]),   64'd5);
      check("s1_p0_a",   64'(iss_src_a[31:0]),  64'hA2);
      check("s1_p0_b",   64'(iss_src_b[31:0]),  64'hB2);
      check("s1_p0_dat", 64'(iss_data[31:0]),   64'h0);
      check("s1_p0_ctl", 64'(iss_ctrl[15:0]),   64'h0A00);
      check("s1_p1_tag", 64'(iss_tag[11:6]),    64'h15);

      // rr_ptr 6, entries 1 and 7 eligible: wrap-around order 7 then 1.
      iss_ready = 2'b11;
      set_entry(1, 0, 0, 32'hA1, 32'hB1, 32'hC1, 16'h0100, 6'h11);
      set_entry(7, 0, 0, 32'hA7, 32'hB7, 32'hC7, 16'h0700, 6'h17);
      #1;
      check("s2_grant", 64'(rs_grant), 64'b1000_0010);
      tick();
      rs_busy[1] = 1'b0; rs_busy[7] = 1'b0;
      check("s2_p0_id", 64'(iss_rs_id[4:0]), 64'd7);
      check("s2_p1_id", 64'(iss_rs_id[9:5]), 64'd1);

      // rr_ptr 2, entry 3 with alusrc and memwr.
      set_entry(3, 0, 0, 32'h33, 32'h99, 32'h10, 16'h0003, 6'h13);
      #1;
      check("s3_grant", 64'(rs_grant), 64'b0000_1000);
      tick();
      rs_busy[3] = 1'b0;
      check("s3_valid",  64'(iss_valid),       64'b01);
      check("s3_src_a",  64'(iss_src_a[31:0]), 64'h33);
      check("s3_src_b",  64'(iss_src_b[31:0]), 64'h10);
      check("s3_data",   64'(iss_data[31:0]),  64'h99);

      // rr_ptr 4, port0 stalled, port1 free; entries 0, 4, 6 eligible.
      iss_ready = 2'b10;
      set_entry(0, 0, 0, 32'hA0, 32'hB0, 32'hC0, 16'h0000, 6'h10);
      set_entry(4, 0, 0, 32'hA4, 32'hB4, 32'hC4, 16'h0400, 6'h14);
      set_entry(6, 0, 0, 32'hA6, 32'hB6, 32'hC6, 16'h0600, 6'h16);
      #1;
      check("s4_grant", 64'(rs_grant), 64'b0001_0000);
      tick();
      rs_busy[4] = 1'b0;
      check("s4_valid",   64'(iss_valid),       64'b11);
      check("s4_p1_id",   64'(iss_rs_id[9:5]),  64'd4);
      check("s4_p0_id",   64'(iss_rs_id[4:0]),  64'd3);
      check("s4_p0_b",    64'(iss_src_b[31:0]), 64'h10);
      check("s4_p0_data", 64'(iss_data[31:0]),  64'h99);

      // Full back-pressure: no grant, outputs and rr_ptr (5) held.
      iss_ready = 2'b00;
      #1;
      check("bp_grant", 64'(rs_grant), 64'h0);
      tick();
      check("bp_valid", 64'(iss_valid),      64'b11);
      check("bp_p1_id", 64'(iss_rs_id[9:5]), 64'd4);
      iss_ready = 2'b11;
      #1;
      check("bp_release_grant", 64'(rs_grant), 64'b0100_0001);
      tick();
      rs_busy[0] = 1'b0; rs_busy[6] = 1'b0;
      check("bp_p0_id", 64'(iss_rs_id[4:0]), 64'd6);
      check("bp_p1_id", 64'(iss_rs_id[9:5]), 64'd0);

      // Pending operands block issue (rr_ptr 1).
      set_entry(4, 6'd3, 0, 32'hE4, 32'hF4, 32'h0, 16'h0400, 6'h24);
      set_entry(6, 0, 6'd1, 32'hE6, 32'hF6, 32'h0, 16'h0600, 6'h26);
      rs_tag_1[2*6 +: 6] = '0; rs_tag_2[2*6 +: 6] = '0;
      #1;
      check("tag_block_grant", 64'(rs_grant), 64'h0);
      tick();
      check("tag_block_valid", 64'(iss_valid), 64'b00);
      rs_tag_1[4*6 +: 6] = '0;
      #1;
      check("tag_clear_grant", 64'(rs_grant), 64'b0001_0000);
      tick();
      rs_busy[4] = 1'b0; rs_busy[6] = 1'b0;
      check("tag_clear_valid", 64'(iss_valid),       64'b01);
      check("tag_clear_a",     64'(iss_src_a[31:0]), 64'hE4);

      // rr_ptr 5: entries 1 and 3 fill both ports, then reset mid-operation.
      set_entry(1, 0, 0, 32'hD1, 32'h0, 32'h0, 16'h0, 6'h31);
      set_entry(3, 0, 0, 32'hD3, 32'h0, 32'h0, 16'h0, 6'h33);
      #1;
      check("pre_rst_grant", 64'(rs_grant), 64'b0000_1010);
      tick();
      rs_busy[1] = 1'b0; rs_busy[3] = 1'b0;
      check("pre_rst_valid", 64'(iss_valid), 64'b11);
      iss_ready = 2'b00;
      set_entry(2, 0, 0, 32'hF2, 32'h0, 32'h0, 16'h0, 6'h32);
      set_entry(6, 0, 0, 32'hF6, 32'h0, 32'h0, 16'h0, 6'h36);
      #2;
      reset = 1'b1;
      #1;
      check("rst_valid", 64'(iss_valid), 64'h0);
      check("rst_grant", 64'(rs_grant),  64'h0);
      check("rst_src_a", 64'(iss_src_a), 64'h0);
      tick();
      reset = 1'b0;
      #1;
      check("post_rst_grant", 64'(rs_grant), 64'b0100_0100);
      tick();
      check("post_rst_p0_id", 64'(iss_rs_id[4:0]), 64'd2);
      check("post_rst_p1_id", 64'(iss_rs_id[9:5]), 64'd6);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
